// File: rtl/train_stream_scoreboard.sv
// train_stream_scoreboard
// Replays stored training cases into a bit-serial network one slice per clock.
// It compares the network's actual output against its delayed ideal output,
// and keeps per-case, per-epoch and total error statistics.
// Each case occupies CPC = SLICES+2 clocks. The two extra clocks let the
// network pipeline drain before the case result is decided.

module train_stream_scoreboard #(
  parameter int N_IN      = 16,
  parameter int N_OUT     = 4,
  parameter int A_PER_CLK = 4,
  parameter int Y_PER_CLK = 1,
  parameter int CASES     = 8,
  parameter int CMP_START = 2,
  parameter int MAX_TRAIN = 1000,
  localparam int SLICES   = N_IN / A_PER_CLK,
  localparam int CPC      = SLICES + 2,
  localparam int CASE_W   = (CASES > 1) ? $clog2(CASES) : 1,
  localparam int IDX_W    = $clog2(CPC)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 wr_en,
  input  logic [CASE_W-1:0]    wr_addr,
  input  logic [N_IN-1:0]      wr_a,
  input  logic [N_OUT-1:0]     wr_y,
  output logic [A_PER_CLK-1:0] a_in,
  output logic [Y_PER_CLK-1:0] y_in,
  input  logic [Y_PER_CLK-1:0] a_out,
  input  logic [Y_PER_CLK-1:0] y_out,
  output logic                 cycle_clk,
  output logic [IDX_W-1:0]     cycle_index,
  output logic [CASE_W-1:0]    case_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 result_valid,
  output logic                 tc_error,
  output logic                 epoch_done,
  output logic [31:0]          total_error,
  output logic [31:0]          last_epoch_error,
  output logic [31:0]          num_train
);

  // Reject geometries where the input and output streams do not line up
  // slice for slice, or where the case index cannot address the memory
  // exactly.
  if ((N_IN % A_PER_CLK) != 0 || (N_OUT % Y_PER_CLK) != 0 ||
      (N_OUT / Y_PER_CLK) != SLICES) begin : g_bad_geometry
    $error("train_stream_scoreboard: N_OUT/Y_PER_CLK must equal N_IN/A_PER_CLK");
  end
  if (CASES < 2 || (CASES & (CASES - 1)) != 0) begin : g_bad_cases
    $error("train_stream_scoreboard: CASES must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Case memory. It is read combinationally so that the slice for the
  // current cycle_index appears on a_in in the same clock. Reset leaves it
  // intact, so stored cases survive an aborted run.
  logic [N_IN-1:0]  mem_a [CASES];
  logic [N_OUT-1:0] mem_y [CASES];

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   cycle_index_reg, cycle_index_next;
  logic [CASE_W-1:0]  case_sel_reg, case_sel_next;
  logic [31:0]        num_train_reg, num_train_next;
  logic [31:0]        total_error_reg, total_error_next;
  logic [31:0]        last_epoch_error_reg, last_epoch_error_next;
  logic [31:0]        epoch_acc_reg, epoch_acc_next;
  logic               sticky_reg, sticky_next;
  logic               result_valid_reg, result_valid_next;
  logic               tc_error_reg, tc_error_next;
  logic               epoch_done_reg, epoch_done_next;

  logic [N_IN-1:0]      a_row;
  logic [N_OUT-1:0]     y_row;
  logic [A_PER_CLK-1:0] a_slice [SLICES];
  logic [Y_PER_CLK-1:0] y_slice [SLICES];
  logic                 cmp_hit;
  logic                 last_cycle;
  logic                 case_result;
  logic [31:0]          num_train_inc;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    sat_inc = (inc && (v != '1)) ? v + 32'd1 : v;
  endfunction

  // Store a case. Writes are accepted only while no run is using the memory.
  always_ff @(posedge clk) begin
    if (!reset && wr_en && (state_reg != RUN)) begin
      mem_a[wr_addr] <= wr_a;
      mem_y[wr_addr] <= wr_y;
    end
  end

  assign a_row = mem_a[case_sel_reg];
  assign y_row = mem_y[case_sel_reg];

  // Split the selected case into slices. Slice 0 holds the least
  // significant bits.
  for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
    assign a_slice[gi] = a_row[gi*A_PER_CLK +: A_PER_CLK];
    assign y_slice[gi] = y_row[gi*Y_PER_CLK +: Y_PER_CLK];
  end

  // Drive the most significant slice first. The drain cycles, and any state
  // other than RUN, drive zeros.
  always_comb begin
    a_in = '0;
    y_in = '0;
    if (state_reg == RUN) begin
      for (int i = 0; i < SLICES; i++) begin
        if (cycle_index_reg == IDX_W'(SLICES - 1 - i)) begin
          a_in = a_in | a_slice[i];
          y_in = y_in | y_slice[i];
        end
      end
    end
  end

  // Early cycles are excluded from the compare because the network output
  // still reflects the previous case.
  assign cmp_hit     = (state_reg == RUN) && (cycle_index_reg >= IDX_W'(CMP_START)) &&
                       (a_out != y_out);
  assign last_cycle  = (state_reg == RUN) && (cycle_index_reg == IDX_W'(CPC - 1));
  assign case_result = sticky_reg | cmp_hit;
  assign num_train_inc = sat_inc(num_train_reg, 1'b1);

  // Next-state logic. It covers sequencing, case completion and epoch
  // bookkeeping.
  always_comb begin
    state_next            = state_reg;
    cycle_index_next      = cycle_index_reg;
    case_sel_next         = case_sel_reg;
    num_train_next        = num_train_reg;
    total_error_next      = total_error_reg;
    last_epoch_error_next = last_epoch_error_reg;
    epoch_acc_next        = epoch_acc_reg;
    sticky_next           = sticky_reg;
    result_valid_next     = 1'b0;
    tc_error_next         = tc_error_reg;
    epoch_done_next       = 1'b0;

    unique case (state_reg)
      IDLE, DONE: begin
        cycle_index_next = '0;
        if (start) begin
          state_next            = RUN;
          case_sel_next         = '0;
          num_train_next        = '0;
          total_error_next      = '0;
          last_epoch_error_next = '0;
          epoch_acc_next        = '0;
          sticky_next           = 1'b0;
        end
      end
      RUN: begin
        if (last_cycle) begin
          cycle_index_next  = '0;
          result_valid_next = 1'b1;
          tc_error_next     = case_result;
          num_train_next    = num_train_inc;
          total_error_next  = sat_inc(total_error_reg, case_result);
          sticky_next       = 1'b0;
          if (case_sel_reg == CASE_W'(CASES - 1)) begin
            // The epoch total includes the case finishing right now.
            case_sel_next         = '0;
            epoch_done_next       = 1'b1;
            last_epoch_error_next = sat_inc(epoch_acc_reg, case_result);
            epoch_acc_next        = '0;
          end else begin
            case_sel_next  = case_sel_reg + CASE_W'(1);
            epoch_acc_next = sat_inc(epoch_acc_reg, case_result);
          end
          if (num_train_inc == 32'(MAX_TRAIN)) begin
            state_next = DONE;
          end
        end else begin
          cycle_index_next = cycle_index_reg + IDX_W'(1);
          if (cmp_hit) begin
            sticky_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register. Reset drops any partial case and clears every output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg            <= IDLE;
      cycle_index_reg      <= '0;
      case_sel_reg         <= '0;
      num_train_reg        <= '0;
      total_error_reg      <= '0;
      last_epoch_error_reg <= '0;
      epoch_acc_reg        <= '0;
      sticky_reg           <= 1'b0;
      result_valid_reg     <= 1'b0;
      tc_error_reg         <= 1'b0;
      epoch_done_reg       <= 1'b0;
    end else begin
      state_reg            <= state_next;
      cycle_index_reg      <= cycle_index_next;
      case_sel_reg         <= case_sel_next;
      num_train_reg        <= num_train_next;
      total_error_reg      <= total_error_next;
      last_epoch_error_reg <= last_epoch_error_next;
      epoch_acc_reg        <= epoch_acc_next;
      sticky_reg           <= sticky_next;
      result_valid_reg     <= result_valid_next;
      tc_error_reg         <= tc_error_next;
      epoch_done_reg       <= epoch_done_next;
    end
  end

  assign cycle_clk        = (state_reg == RUN) && (cycle_index_reg == '0);
  assign cycle_index      = cycle_index_reg;
  assign case_sel         = case_sel_reg;
  assign busy             = (state_reg == RUN);
  assign done             = (state_reg == DONE);
  assign result_valid     = result_valid_reg;
  assign tc_error         = tc_error_reg;
  assign epoch_done       = epoch_done_reg;
  assign total_error      = total_error_reg;
  assign last_epoch_error = last_epoch_error_reg;
  assign num_train        = num_train_reg;

endmodule

// File: tb/tb_train_stream_scoreboard.sv
// tb_train_stream_scoreboard
// Scoreboard bench. The stimulus pushes the expected case results for each
// run into a queue. A monitor pops and compares one entry on every
// result_valid pulse.
`timescale 1ns/1ps

module tb_train_stream_scoreboard;

  localparam int N_IN = 16, N_OUT = 4, A_PER_CLK = 4, Y_PER_CLK = 1;
  localparam int CASES = 8, CMP_START = 2, MAX_TRAIN = 16;

  logic        clk;
  logic        reset, start, wr_en, tb_clr, a_out;
  logic [2:0]  wr_addr;
  logic [15:0] wr_a;
  logic [3:0]  wr_y;
  logic [3:0]  a_in;
  logic [0:0]  y_in;
  logic        y_out;
  logic        cycle_clk, busy, done, result_valid, tc_error, epoch_done;
  logic [2:0]  cycle_index, case_sel;
  logic [31:0] total_error, last_epoch_error, num_train;

  train_stream_scoreboard #(
    .N_IN(N_IN), .N_OUT(N_OUT), .A_PER_CLK(A_PER_CLK), .Y_PER_CLK(Y_PER_CLK),
    .CASES(CASES), .CMP_START(CMP_START), .MAX_TRAIN(MAX_TRAIN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_a(wr_a), .wr_y(wr_y), .a_in(a_in), .y_in(y_in), .a_out(a_out),
    .y_out(y_out), .cycle_clk(cycle_clk), .cycle_index(cycle_index),
    .case_sel(case_sel), .busy(busy), .done(done), .result_valid(result_valid),
    .tc_error(tc_error), .epoch_done(epoch_done), .total_error(total_error),
    .last_epoch_error(last_epoch_error), .num_train(num_train)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        tc;
    logic        ep;
    logic [31:0] nt;
    logic [31:0] te;
    logic [31:0] lee;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0, n_err = 0, n_epoch = 0, n_rv = 0;
  logic [5:0]  plan [0:31];   // per run-case: bit k => mismatch at cycle_index k
  logic [4:0]  tb_case;
  logic        a_tog;
  logic [15:0] a_tab [0:7];
  logic [3:0]  y_tab [0:7];
  logic [3:0]  exp_a0 [0:5];
  logic [0:0]  exp_y0 [0:5];

  // Network stand-in: actual output toggles and the ideal output follows it,
  // except where the plan injects a mismatch.
  always @(posedge clk) begin
    a_tog <= ~a_tog;
    if (reset || tb_clr) tb_case <= '0;
    else if (result_valid === 1'b1) tb_case <= tb_case + 5'd1;
  end
  assign a_out = a_tog;
  assign y_out = a_tog ^ ((busy === 1'b1) && plan[tb_case][cycle_index]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: pop and compare on every case result.
  always @(negedge clk) begin
    if (epoch_done === 1'b1) begin
      n_epoch++;
      chk("epoch_done_with_result_valid", {31'd0, result_valid}, 32'd1);
    end
    if (result_valid === 1'b1) begin
      n_rv++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result_valid: got pulse at num_train=%0d, required none", num_train);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("case%0d_tc_error", mon_e.nt - 1), {31'd0, tc_error}, {31'd0, mon_e.tc});
        chk($sformatf("case%0d_num_train", mon_e.nt - 1), num_train, mon_e.nt);
        chk($sformatf("case%0d_total_error", mon_e.nt - 1), total_error, mon_e.te);
        chk($sformatf("case%0d_epoch_done", mon_e.nt - 1), {31'd0, epoch_done}, {31'd0, mon_e.ep});
        chk($sformatf("case%0d_last_epoch_error", mon_e.nt - 1), last_epoch_error, mon_e.lee);
      end
    end
  end

  // Expected results for the first n cases of a run under the current plan.
  task automatic push_run(input int n);
    logic [31:0] acc, te, lee;
    exp_t        e;
    logic        err;
    acc = 0; te = 0; lee = 0;
    for (int i = 0; i < n; i++) begin
      err = |(plan[5'(i)] >> CMP_START);
      te  = te + {31'd0, err};
      acc = acc + {31'd0, err};
      e.ep = ((i % CASES) == CASES - 1);
      if (e.ep) begin
        lee = acc;
        acc = 0;
      end
      e.tc  = err;
      e.nt  = i + 1;
      e.te  = te;
      e.lee = lee;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_cycle_clk"}, {31'd0, cycle_clk}, 32'd0);
    chk({tag, "_cycle_index"}, {29'd0, cycle_index}, 32'd0);
    chk({tag, "_case_sel"}, {29'd0, case_sel}, 32'd0);
    chk({tag, "_a_in"}, {28'd0, a_in}, 32'd0);
    chk({tag, "_y_in"}, {31'd0, y_in}, 32'd0);
    chk({tag, "_result_valid"}, {31'd0, result_valid}, 32'd0);
    chk({tag, "_tc_error"}, {31'd0, tc_error}, 32'd0);
    chk({tag, "_epoch_done"}, {31'd0, epoch_done}, 32'd0);
    chk({tag, "_total_error"}, total_error, 32'd0);
    chk({tag, "_last_epoch_error"}, last_epoch_error, 32'd0);
    chk({tag, "_num_train"}, num_train, 32'd0);
  endtask

  // Call at the negedge where cycle_index 0 of case 0 is presented.
  task automatic check_case0_stream(input string tag);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s_a_in_k%0d", tag, k), {28'd0, a_in}, {28'd0, exp_a0[k]});
      chk($sformatf("%s_y_in_k%0d", tag, k), {31'd0, y_in}, {31'd0, exp_y0[k]});
      chk($sformatf("%s_cycle_index_k%0d", tag, k), {29'd0, cycle_index}, k);
      chk($sformatf("%s_cycle_clk_k%0d", tag, k), {31'd0, cycle_clk}, {31'd0, (k == 0)});
      @(negedge clk);
    end
  endtask

  task automatic wait_for_pos(input int cs, input int ci, input string name);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (case_sel == 3'(cs) && cycle_index == 3'(ci)) found = 1;
      else @(negedge clk);
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout, got case_sel=%0d cycle_index=%0d, required %0d/%0d",
               name, case_sel, cycle_index, cs, ci);
    end
  endtask

  task automatic wait_done(input string name);
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (done === 1'b1) found = 1;
      else @(negedge clk);
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout, got done=%b, required 1", name, done);
    end
  endtask

  task automatic do_start();
    tb_clr = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    tb_clr = 1'b0;
  endtask

  int rv0, ep0;

  initial begin
    a_tab = '{16'h0fff, 16'h1234, 16'h5678, 16'h9abc, 16'hdef0, 16'h2468, 16'hace1, 16'h3579};
    y_tab = '{4'b0111, 4'ha, 4'h5, 4'hc, 4'h3, 4'h9, 4'h6, 4'hf};
    exp_a0 = '{4'h0, 4'hf, 4'hf, 4'hf, 4'h0, 4'h0};
    exp_y0 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 32; i++) plan[i] = '0;
    a_tog = 1'b0;
    tb_clr = 1'b0;
    // Reset wins over start and wr_en.
    reset = 1'b1; start = 1'b1; wr_en = 1'b1;
    wr_addr = '0; wr_a = '1; wr_y = '1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0; start = 1'b0; wr_en = 1'b0;

    for (int i = 0; i < CASES; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_a = a_tab[i]; wr_y = y_tab[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("idle_after_writes_busy", {31'd0, busy}, 32'd0);

    // Run A: case0 idx5 error, case1 idx1 ignored, case3 idx2 error,
    // case5 idx0/1 ignored; second epoch clean.
    plan[0] = 6'b100000;
    plan[1] = 6'b000010;
    plan[3] = 6'b000100;
    plan[5] = 6'b000011;
    push_run(16);
    rv0 = n_rv; ep0 = n_epoch;
    do_start();
    chk("runA_busy", {31'd0, busy}, 32'd1);
    check_case0_stream("runA");
    wait_for_pos(4, 0, "runA_reach_case4");
    start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_a = 16'hffff; wr_y = 4'hf;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    chk("start_in_run_case_sel", {29'd0, case_sel}, 32'd4);
    chk("start_in_run_cycle_index", {29'd0, cycle_index}, 32'd1);
    wait_done("runA_done");
    chk("runA_done", {31'd0, done}, 32'd1);
    chk("runA_busy_low", {31'd0, busy}, 32'd0);
    chk("runA_num_train", num_train, 32'd16);
    chk("runA_total_error", total_error, 32'd2);
    chk("runA_last_epoch_error", last_epoch_error, 32'd0);
    repeat (3) @(negedge clk);
    chk("runA_results", n_rv - rv0, 16);
    chk("runA_epochs", n_epoch - ep0, 2);
    chk("done_hold_num_train", num_train, 32'd16);
    chk("done_hold_total_error", total_error, 32'd2);
    chk("done_cycle_index", {29'd0, cycle_index}, 32'd0);
    chk("done_a_in", {28'd0, a_in}, 32'd0);
    chk("done_y_in", {31'd0, y_in}, 32'd0);
    chk("done_result_valid", {31'd0, result_valid}, 32'd0);

    // Run B: start from DONE clears counters; reset at case2 idx3 aborts.
    for (int i = 0; i < 32; i++) plan[i] = '0;
    push_run(2);
    do_start();
    chk("runB_busy", {31'd0, busy}, 32'd1);
    chk("runB_done_low", {31'd0, done}, 32'd0);
    chk("runB_num_train_cleared", num_train, 32'd0);
    chk("runB_total_error_cleared", total_error, 32'd0);
    chk("runB_last_epoch_cleared", last_epoch_error, 32'd0);
    chk("runB_case_sel_cleared", {29'd0, case_sel}, 32'd0);
    check_case0_stream("runB");
    wait_for_pos(2, 3, "runB_reach_case2_idx3");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midrun_reset");
    chk("runB_queue_drained", exp_q.size(), 32'd0);
    repeat (8) @(negedge clk);
    chk("after_reset_idle_busy", {31'd0, busy}, 32'd0);
    chk("after_reset_no_result", {31'd0, result_valid}, 32'd0);

    // Run C: clean run, case memory replays unchanged.
    push_run(16);
    rv0 = n_rv; ep0 = n_epoch;
    do_start();
    check_case0_stream("runC");
    wait_done("runC_done");
    chk("runC_num_train", num_train, 32'd16);
    chk("runC_total_error", total_error, 32'd0);
    chk("runC_last_epoch_error", last_epoch_error, 32'd0);
    repeat (2) @(negedge clk);
    chk("runC_results", n_rv - rv0, 16);
    chk("runC_epochs", n_epoch - ep0, 2);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
